// File: rtl/regfile_pkg.sv
// Shared types, default parameters and port-slicing helper for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clrState_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_N_RD     = 4;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_OUT_IDX  = 6;

    // Bit offsets of one read port inside the packed address and data buses.
    typedef struct packed {
        int addrLsb;
        int dataLsb;
    } portSlice_t;

    function automatic portSlice_t portSlice(input int port, input int addrW, input int dataW);
        portSlice_t s;
        s.addrLsb = port * addrW;
        s.dataLsb = port * dataW;
        return s;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks every entry once after reset or on request, and flags writes
// that arrive while it is running.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clearReq,
    input  logic              anyWrEn,
    output logic              busy,
    output logic              wrDrop,
    output logic              clrWe,
    output logic [ADDR_W-1:0] clrAddr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clrState_t         state;
    clrState_t         stateNext;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cntNext;

    // Next-state logic: a request starts a sweep from entry 0; the sweep ends after the last entry.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (clearReq) begin
                    stateNext = CLEAR;
                    cntNext   = '0;
                end
            end
            CLEAR: begin
                cntNext = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

    // State, counter and status flags; reset always restarts the sweep at entry 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy   <= 1'b1;
            wrDrop <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            busy   <= (stateNext == CLEAR);
            wrDrop <= anyWrEn & busy;
        end
    end

    // No array write happens on an edge where reset is held.
    assign clrWe   = (state == CLEAR) & ~reset;
    assign clrAddr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, N_RD combinational read
// ports with optional same-cycle bypass, a hard-wired zero entry and a tap output.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_RD     = DEF_N_RD,
    parameter int BYPASS   = DEF_BYPASS,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int OUT_IDX  = DEF_OUT_IDX
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_req,
    output logic                   busy,
    output logic                   wr_drop,
    input  logic                   wr0_en,
    input  logic [ADDR_W-1:0]      wr0_addr,
    input  logic [DATA_W-1:0]      wr0_data,
    input  logic                   wr1_en,
    input  logic [ADDR_W-1:0]      wr1_addr,
    input  logic [DATA_W-1:0]      wr1_data,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]      reg_out
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam bit                ZERO_EN = (ZERO_REG != 0);
    localparam bit                BYP_EN  = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] OUT_A   = ADDR_W'(OUT_IDX);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clrWe;
    logic [ADDR_W-1:0] clrAddr;
    logic              wr0Ok;
    logic              wr1Ok;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) uClear (
        .clock    (clock),
        .reset    (reset),
        .clearReq (clear_req),
        .anyWrEn  (wr0_en | wr1_en),
        .busy     (busy),
        .wrDrop   (wr_drop),
        .clrWe    (clrWe),
        .clrAddr  (clrAddr)
    );

    // Writes are accepted only when idle; entry 0 is silently protected when hard-wired to zero.
    assign wr0Ok = wr0_en & ~busy & ~reset & ~(ZERO_EN && (wr0_addr == '0));
    assign wr1Ok = wr1_en & ~busy & ~reset & ~(ZERO_EN && (wr1_addr == '0));

    // Array update: clear sweep owns the array while busy; port 1 lands last so it wins on a collision.
    always_ff @(posedge clock) begin
        if (clrWe) begin
            mem[clrAddr] <= '0;
        end else begin
            if (wr0Ok) begin
                mem[wr0_addr] <= wr0_data;
            end
            if (wr1Ok) begin
                mem[wr1_addr] <= wr1_data;
            end
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : gRd
        localparam portSlice_t SL = portSlice(k, ADDR_W, DATA_W);

        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[SL.addrLsb +: ADDR_W];

        // Read priority: busy, zero entry, port-1 bypass, port-0 bypass, then stored value.
        always_comb begin
            data = mem[addr];
            if (busy) begin
                data = '0;
            end else if (ZERO_EN && (addr == '0)) begin
                data = '0;
            end else if (BYP_EN && wr1_en && (wr1_addr == addr)) begin
                data = wr1_data;
            end else if (BYP_EN && wr0_en && (wr0_addr == addr)) begin
                data = wr0_data;
            end
        end

        assign rd_data[SL.dataLsb +: DATA_W] = data;
    end

    assign reg_out = busy ? '0 : mem[OUT_A];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with defaults (bypass, zero entry) and
// one with BYPASS=0 / ZERO_REG=0 driven by the same inputs.
module tb_regfile_mp;

    logic         clock = 1'b0;
    logic         reset;
    logic         clear_req;
    logic         wr0_en;
    logic [4:0]   wr0_addr;
    logic [31:0]  wr0_data;
    logic         wr1_en;
    logic [4:0]   wr1_addr;
    logic [31:0]  wr1_data;
    logic [19:0]  rd_addr;

    logic         busyB, wrDropB, busyN, wrDropN;
    logic [127:0] rdDataB, rdDataN;
    logic [31:0]  regOutB, regOutN;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_mp dut (
        .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busyB), .wr_drop(wrDropB),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rdDataB), .reg_out(regOutB)
    );

    regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dutN (
        .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busyN), .wr_drop(wrDropN),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rdDataN), .reg_out(regOutN)
    );

    typedef struct {
        logic         w0e;
        logic [4:0]   w0a;
        logic [31:0]  w0d;
        logic         w1e;
        logic [4:0]   w1a;
        logic [31:0]  w1d;
        logic [19:0]  ra;
        logic [127:0] expB;
        logic [127:0] expN;
        logic [31:0]  expOut;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                          input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                          input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                          input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2, input logic [31:0] b3,
                          input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2, input logic [31:0] n3,
                          input logic [31:0] out);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ra     = {a3, a2, a1, a0};
        v.expB   = {b3, b2, b1, b0};
        v.expN   = {n3, n2, n1, n0};
        v.expOut = out;
        vecs.push_back(v);
    endtask

    task automatic setRd(input logic [4:0] a);
        rd_addr = {a, a, a, a};
    endtask

    task automatic idleInputs();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        clear_req = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        for (int a = 0; a < 32; a++) begin
            setRd(5'(a));
            #1;
            check($sformatf("%s B entry%0d", tag, a), rdDataB[31:0], 32'h0);
            check($sformatf("%s N entry%0d", tag, a), rdDataN[31:0], 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int dropsB;
        int dropsN;

        reset = 1'b1;
        idleInputs();
        rd_addr = '0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst busyB", 32'(busyB), 32'h1);
        check("rst busyN", 32'(busyN), 32'h1);
        check("rst wr_dropB", 32'(wrDropB), 32'h0);
        check("rst rd_dataB", rdDataB[31:0], 32'h0);
        check("rst rd_dataN", rdDataN[31:0], 32'h0);
        check("rst reg_outB", regOutB, 32'h0);

        // Clear latency after reset release: busy through edge 31, low after edge 32
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("init busyB edge%0d", i), 32'(busyB), (i <= 31) ? 32'h1 : 32'h0);
            check($sformatf("init busyN edge%0d", i), 32'(busyN), (i <= 31) ? 32'h1 : 32'h0);
        end
        checkAllZero("init");

        // Directed vectors: rd_data sampled before the edge that applies the writes
        addVec(1, 3, 32'hDEADBEEF, 0, 0, 0,  3, 3, 0, 1,
               32'hDEADBEEF, 32'hDEADBEEF, 0, 0,  0, 0, 0, 0,  0);
        addVec(0, 0, 0, 0, 0, 0,  3, 2, 3, 0,
               32'hDEADBEEF, 0, 32'hDEADBEEF, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0,  0);
        addVec(1, 5, 32'h11, 1, 5, 32'h22,  5, 3, 5, 4,
               32'h22, 32'hDEADBEEF, 32'h22, 0,  0, 32'hDEADBEEF, 0, 0,  0);
        addVec(0, 0, 0, 0, 0, 0,  5, 5, 3, 0,
               32'h22, 32'h22, 32'hDEADBEEF, 0,  32'h22, 32'h22, 32'hDEADBEEF, 0,  0);
        addVec(0, 0, 0, 1, 0, 32'hFFFFFFFF,  0, 0, 5, 3,
               0, 0, 32'h22, 32'hDEADBEEF,  0, 0, 32'h22, 32'hDEADBEEF,  0);
        addVec(0, 0, 0, 0, 0, 0,  0, 5, 0, 3,
               0, 32'h22, 0, 32'hDEADBEEF,  32'hFFFFFFFF, 32'h22, 32'hFFFFFFFF, 32'hDEADBEEF,  0);
        addVec(1, 6, 32'h1234, 1, 9, 32'hA5A5A5A5,  6, 9, 6, 9,
               32'h1234, 32'hA5A5A5A5, 32'h1234, 32'hA5A5A5A5,  0, 0, 0, 0,  0);
        addVec(1, 9, 32'h55, 1, 6, 32'h77,  9, 6, 10, 31,
               32'h55, 32'h77, 0, 0,  32'hA5A5A5A5, 32'h1234, 0, 0,  32'h1234);
        addVec(0, 0, 0, 0, 0, 0,  9, 6, 9, 6,
               32'h55, 32'h77, 32'h55, 32'h77,  32'h55, 32'h77, 32'h55, 32'h77,  32'h77);
        addVec(1, 1, 32'hCAFEF00D, 1, 31, 32'h80000001,  1, 31, 1, 31,
               32'hCAFEF00D, 32'h80000001, 32'hCAFEF00D, 32'h80000001,  0, 0, 0, 0,  32'h77);
        addVec(0, 0, 0, 0, 0, 0,  1, 31, 6, 3,
               32'hCAFEF00D, 32'h80000001, 32'h77, 32'hDEADBEEF,
               32'hCAFEF00D, 32'h80000001, 32'h77, 32'hDEADBEEF,  32'h77);

        foreach (vecs[i]) begin
            @(negedge clock);
            wr0_en = vecs[i].w0e; wr0_addr = vecs[i].w0a; wr0_data = vecs[i].w0d;
            wr1_en = vecs[i].w1e; wr1_addr = vecs[i].w1a; wr1_data = vecs[i].w1d;
            rd_addr = vecs[i].ra;
            #2;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("vec%0d B rd%0d", i, k), rdDataB[k*32 +: 32], vecs[i].expB[k*32 +: 32]);
                check($sformatf("vec%0d N rd%0d", i, k), rdDataN[k*32 +: 32], vecs[i].expN[k*32 +: 32]);
            end
            check($sformatf("vec%0d reg_outB", i), regOutB, vecs[i].expOut);
            check($sformatf("vec%0d reg_outN", i), regOutN, vecs[i].expOut);
            check($sformatf("vec%0d wr_dropB", i), 32'(wrDropB), 32'h0);
            check($sformatf("vec%0d wr_dropN", i), 32'(wrDropN), 32'h0);
        end

        // clear_req with a write arriving during the sweep
        @(negedge clock);
        idleInputs();
        wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h1234;
        @(negedge clock);
        idleInputs();
        check("preclr reg_outB", regOutB, 32'h1234);
        check("preclr reg_outN", regOutN, 32'h1234);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        check("clr busyB", 32'(busyB), 32'h1);
        check("clr reg_outB", regOutB, 32'h0);
        check("clr reg_outN", regOutN, 32'h0);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h0000BEEF;
        setRd(5'd7);
        #1;
        check("clr bypass blocked B", rdDataB[31:0], 32'h0);
        check("clr bypass blocked N", rdDataN[63:32], 32'h0);
        edges = 0; dropsB = 0; dropsN = 0;
        while (busyB && edges < 40) begin
            @(negedge clock);
            edges++;
            wr0_en = 1'b0;
            if (wrDropB) dropsB++;
            if (wrDropN) dropsN++;
        end
        check("clr edges", 32'(edges), 32'd32);
        check("clr dropsB", 32'(dropsB), 32'd1);
        check("clr dropsN", 32'(dropsN), 32'd1);
        setRd(5'd7);
        #1;
        check("clr entry7 B", rdDataB[31:0], 32'h0);
        check("clr entry7 N", rdDataN[31:0], 32'h0);
        check("postclr reg_outB", regOutB, 32'h0);

        // Reset asserted at cnt=10 mid-clear, held two cycles
        @(negedge clock);
        wr0_en = 1'b1; wr0_addr = 5'd2;  wr0_data = 32'h6;
        wr1_en = 1'b1; wr1_addr = 5'd20; wr1_data = 32'h5;
        @(negedge clock);
        idleInputs();
        setRd(5'd20);
        #1;
        check("pre mid entry20 N", rdDataN[31:0], 32'h5);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd25; wr0_data = 32'h9;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check($sformatf("midrst%0d busyB", i), 32'(busyB), 32'h1);
            check($sformatf("midrst%0d wr_dropB", i), 32'(wrDropB), 32'h0);
            check($sformatf("midrst%0d wr_dropN", i), 32'(wrDropN), 32'h0);
        end
        reset = 1'b0;
        idleInputs();
        edges = 0;
        while (busyB && edges < 40) begin
            @(negedge clock);
            edges++;
        end
        check("midrst edges", 32'(edges), 32'd32);
        checkAllZero("midrst");

        // First write after the sweep is accepted
        wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'h42;
        setRd(5'd12);
        #1;
        check("first wr bypass B", rdDataB[31:0], 32'h42);
        check("first wr old N", rdDataN[31:0], 32'h0);
        @(negedge clock);
        idleInputs();
        #1;
        check("first wr stored B", rdDataB[31:0], 32'h42);
        check("first wr stored N", rdDataN[31:0], 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
